capture_trigger_engine: RTL
===========================

// Module: capture_trigger_engine
// PURPOSE
//  Capture datapath that sits directly downstream of the capture_system AXI4-Lite register bank.
//  - Consumes the bank's control/config fields (start, abort, length, trigger mode, threshold).
//  - Arms on start, waits for a trigger, then writes a fixed-length burst of AXI-Stream samples
//    into a single-port capture buffer.
//  - Returns status (busy/armed/done/count) and a completion interrupt to the register bank.
// PARAMETERS
//  DATA_WIDTH  32  sample width; threshold compare is signed at this width
//  ADDR_WIDTH  12  capture buffer address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  ACLK           in   1             clock; all ports synchronous to it
//  ARESET         in   1             asynchronous, active-high reset
//  ctrl_start     in   1             1-cycle pulse: arm a capture
//  ctrl_abort     in   1             1-cycle pulse: cancel any capture
//  cfg_length     in   ADDR_WIDTH+1  samples to capture; 0 means DEPTH; values >DEPTH clamp to DEPTH
//  cfg_trig_mode  in   2             0 immediate, 1 ext_trig rising edge, 2 level >= threshold, 3 = mode 0
//  cfg_threshold  in   DATA_WIDTH    signed threshold for mode 2
//  ext_trig       in   1             external trigger, already synchronous to ACLK
//  s_axis_tdata   in   DATA_WIDTH    sample data
//  s_axis_tvalid  in   1             sample valid
//  s_axis_tready  out  1             sample ready
//  buf_we         out  1             buffer write enable
//  buf_addr       out  ADDR_WIDTH    buffer write address
//  buf_wdata      out  DATA_WIDTH    buffer write data
//  sts_busy       out  1             state is ARMED or CAPTURE
//  sts_armed      out  1             state is ARMED
//  sts_done       out  1             state is DONE
//  sts_count      out  ADDR_WIDTH+1  samples written in the current/last capture
//  irq            out  1             1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (ARESET=1, async)
//   - State IDLE; every output 0, including s_axis_tready.
//   - s_axis_tready is registered 1 from the first edge after reset release and stays 1;
//     the engine never backpressures. Beats outside CAPTURE or the trigger beat are discarded.
//   - ext_trig_q (registered previous ext_trig) resets to 0.
//  Config latching
//   - cfg_length and cfg_trig_mode are latched on the ctrl_start edge that arms.
//   - cfg_threshold is sampled live.
//  States: IDLE, ARMED, CAPTURE, DONE
//   - IDLE/DONE: ctrl_start -> ARMED. sts_count <= 0, sts_done <= 0. ext_trig_q keeps tracking.
//   - ARMED: trig = mode0 ? 1 : mode1 ? (ext_trig & ~ext_trig_q) : (tvalid & $signed(tdata) >= $signed(thr)).
//     - trig & tvalid: this beat is written as index 0;
//       next state is DONE if length==1, else CAPTURE.
//     - trig & ~tvalid (modes 0/1): -> CAPTURE; the first later valid beat is index 0.
//   - CAPTURE: every tvalid beat is written at addr = count; count++.
//     The beat that makes count == length -> DONE.
//   - ctrl_abort in any state: -> IDLE. sts_count is held; no irq; sts_done = 0.
//     Abort wins over a simultaneous start or final beat.
//   - ctrl_start while ARMED or CAPTURE is ignored.
//  Timing
//   - Write latency is 1 cycle: a beat accepted at edge t gives buf_we=1 with addr/data
//     valid from t to t+1.
//   - sts_count increments on the same edge buf_we is asserted.
//   - DONE is entered, and irq pulses, on the edge that issues the last write.
//   - buf_addr wraps naturally only at length = DEPTH; the last address is DEPTH-1.
//   - buf_we never asserts in IDLE or DONE, except to complete an already-accepted final beat.
// TESTING
//  1. Reset, start mode0 length=4, stream 0xA,0xB,0xC,0xD back-to-back
//     -> addr 0..3 = A..D; irq once; sts_done=1; count=4.
//  2. Mode1, tvalid held high with 1,2,3..., ext_trig rises with data=7, length=3
//     -> writes 7,8,9; no write before the edge.
//  3. Mode2 thr=-5, data -9,-6,-5,0, length=2
//     -> writes -5,0; sts_armed=1 until the -5 beat.
//  4. length=0, ADDR_WIDTH=4, mode0 -> exactly 16 writes, addr 0..15, count=16.
//  5. Abort after 2 of 8 beats -> IDLE; count=2; no irq. A start during CAPTURE is ignored;
//     start+abort in the same cycle -> IDLE.
//  6. length=1 with the trigger beat valid -> a single write at addr 0; irq on the next edge;
//     a restart from DONE clears count/done.

Source files
------------

// File: rtl/capture_trigger_engine_if.sv
// AXI-Stream sample channel feeding the capture engine.
interface capture_trigger_engine_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/capture_trigger_engine.sv
// Capture engine: arms on start, waits for a trigger, then writes a fixed-length burst of
// stream samples into a single-port capture buffer and reports status plus a done interrupt.
module capture_trigger_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ctrl_start,
    input  logic                  ctrl_abort,
    input  logic [ADDR_WIDTH:0]   cfg_length,
    input  logic [1:0]            cfg_trig_mode,
    input  logic [DATA_WIDTH-1:0] cfg_threshold,
    input  logic                  ext_trig,
    capture_trigger_engine_if.slave s_axis,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  sts_busy,
    output logic                  sts_armed,
    output logic                  sts_done,
    output logic [ADDR_WIDTH:0]   sts_count,
    output logic                  irq
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    // Buffer depth expressed at count width (2**ADDR_WIDTH).
    localparam logic [ADDR_WIDTH:0] DepthVal = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [1:0]            mode_q, mode_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  irq_q, irq_d;
    logic                  tready_q;
    logic                  ext_trig_q;

    logic [ADDR_WIDTH:0]   len_eff;
    logic                  beat;
    logic                  trig;
    logic                  accept;

    // Length clamp, beat qualification and trigger decode for the latched mode.
    always_comb begin
        len_eff = cfg_length;
        if (cfg_length == '0 || cfg_length > DepthVal) begin
            len_eff = DepthVal;
        end
        beat = s_axis.tvalid & tready_q;
        case (mode_q)
            2'd1:    trig = ext_trig & ~ext_trig_q;
            2'd2:    trig = beat & ($signed(s_axis.tdata) >= $signed(cfg_threshold));
            default: trig = 1'b1;
        endcase
    end

    // Next-state: abort dominates everything, then arming, triggering and burst writes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        irq_d   = 1'b0;
        accept  = 1'b0;
        if (ctrl_abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (ctrl_start) begin
                        state_d = StArmed;
                        count_d = '0;
                        len_d   = len_eff;
                        mode_d  = cfg_trig_mode;
                    end
                end
                StArmed: begin
                    if (trig) begin
                        state_d = StCapture;
                        accept  = beat;
                    end
                end
                StCapture: accept = beat;
                default:   state_d = StIdle;
            endcase
            // count_q is zero in ARMED, so the trigger beat lands at index 0.
            if (accept) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_WIDTH-1:0];
                wdata_d = s_axis.tdata;
                count_d = count_q + (ADDR_WIDTH + 1)'(1);
                if (count_d == len_q) begin
                    state_d = StDone;
                    irq_d   = 1'b1;
                end
            end
        end
    end

    // State and registered outputs; tready rises on the first edge after reset and stays high.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= StIdle;
            count_q    <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            irq_q      <= 1'b0;
            tready_q   <= 1'b0;
            ext_trig_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            irq_q      <= irq_d;
            tready_q   <= 1'b1;
            ext_trig_q <= ext_trig;
        end
    end

    assign s_axis.tready = tready_q;
    assign buf_we        = we_q;
    assign buf_addr      = addr_q;
    assign buf_wdata     = wdata_q;
    assign sts_busy      = (state_q == StArmed) || (state_q == StCapture);
    assign sts_armed     = (state_q == StArmed);
    assign sts_done      = (state_q == StDone);
    assign sts_count     = count_q;
    assign irq           = irq_q;

endmodule
